// File: rtl/instr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_seq_ctrl
// Purpose  : Multi-cycle instruction sequencer. Drives the fetch, IR load,
//            decode, execute and writeback cycle. Requests instructions from
//            instruction memory, pulses the IR write enable, decodes the
//            opcode held in the IR, and issues ALU and register-file control.
//            Owns the program counter.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-high reset
//            start        - begin execution from pc = 0 (sampled in IDLE)
//            instr[15:0]  - current IR contents, opcode = instr[15:12]
//            imem_ready   - instruction memory data valid
//            imem_req     - fetch request, address = pc
//            pc[PC_W-1:0] - program counter
//            ir_write_en  - one-cycle IR load pulse
//            rf_write_en  - one-cycle register-file write pulse
//            alu_op[3:0]  - ALU operation, valid EXEC through WB
//            busy         - high outside IDLE and HALT
//            halted       - high in HALT
//            fetch_err    - sticky fetch timeout flag
//            illegal      - sticky undefined-opcode flag
// Revision : 1.0 - initial release
// ============================================================================
module instr_seq_ctrl #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     instr,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [PC_W-1:0] pc,
    output logic            ir_write_en,
    output logic            rf_write_en,
    output logic [3:0]      alu_op,
    output logic            busy,
    output logic            halted,
    output logic            fetch_err,
    output logic            illegal
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_LOAD   = 3'd2;
    localparam logic [2:0] c_ST_DECODE = 3'd3;
    localparam logic [2:0] c_ST_EXEC   = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_HALT   = 3'd6;

    // The counter holds the number of FETCH cycles already spent without
    // data, so the TIMEOUT-th empty cycle is the one where it equals
    // TIMEOUT-1. A ready in that same cycle still wins.
    localparam logic [7:0]      c_TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0]      c_CNT_ONE = 8'd1;
    localparam logic [PC_W-1:0] c_PC_ONE  = PC_W'(1);
    localparam logic [PC_W-1:0] c_PC_ZERO = '0;

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_cnt;
    logic [3:0]      r_alu_op;
    logic            r_is_jmp;
    logic            r_illegal;
    logic            r_fetch_err;
    logic            r_imem_req;
    logic            r_ir_write_en;
    logic            r_rf_write_en;
    logic            r_busy;
    logic            r_halted;

    logic [2:0]      w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic [7:0]      w_cnt_nxt;
    logic [3:0]      w_alu_op_nxt;
    logic            w_is_jmp_nxt;
    logic            w_illegal_nxt;
    logic            w_fetch_err_nxt;
    logic [3:0]      w_opcode;

    assign w_opcode = instr[15:12];

    // Upper instruction bits above the jump target are not used here.
    logic w_unused;
    assign w_unused = ^instr;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_cnt_nxt       = r_cnt;
        w_alu_op_nxt    = r_alu_op;
        w_is_jmp_nxt    = r_is_jmp;
        w_illegal_nxt   = r_illegal;
        w_fetch_err_nxt = r_fetch_err;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = c_ST_FETCH;
                    w_pc_nxt      = c_PC_ZERO;
                    w_cnt_nxt     = 8'd0;
                    w_illegal_nxt = 1'b0;
                end
            end
            c_ST_FETCH: begin
                if (imem_ready) begin
                    w_state_nxt = c_ST_LOAD;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt     = c_ST_HALT;
                    w_fetch_err_nxt = 1'b1;
                    w_cnt_nxt       = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_LOAD: begin
                // pc advances only here, while imem_req is low.
                w_pc_nxt    = r_pc + c_PC_ONE;
                w_state_nxt = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                w_is_jmp_nxt = 1'b0;
                case (w_opcode)
                    4'h0: w_state_nxt = c_ST_FETCH;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        w_state_nxt  = c_ST_EXEC;
                        w_alu_op_nxt = w_opcode;
                    end
                    4'h8: begin
                        w_state_nxt  = c_ST_EXEC;
                        w_is_jmp_nxt = 1'b1;
                    end
                    4'hF: w_state_nxt = c_ST_HALT;
                    default: begin
                        // Undefined opcodes flag and then behave as NOP.
                        w_illegal_nxt = 1'b1;
                        w_state_nxt   = c_ST_FETCH;
                    end
                endcase
            end
            c_ST_EXEC: begin
                if (r_is_jmp) begin
                    w_pc_nxt    = instr[PC_W-1:0];
                    w_state_nxt = c_ST_FETCH;
                end else begin
                    w_state_nxt = c_ST_WB;
                end
            end
            c_ST_WB:   w_state_nxt = c_ST_FETCH;
            c_ST_HALT: w_state_nxt = c_ST_HALT;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State and all outputs are registered. Outputs are decoded from the
    // next state so they line up with the state they describe and cannot
    // glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_pc          <= c_PC_ZERO;
            r_cnt         <= 8'd0;
            r_alu_op      <= 4'd0;
            r_is_jmp      <= 1'b0;
            r_illegal     <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_imem_req    <= 1'b0;
            r_ir_write_en <= 1'b0;
            r_rf_write_en <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_alu_op      <= w_alu_op_nxt;
            r_is_jmp      <= w_is_jmp_nxt;
            r_illegal     <= w_illegal_nxt;
            r_fetch_err   <= w_fetch_err_nxt;
            r_imem_req    <= (w_state_nxt == c_ST_FETCH);
            r_ir_write_en <= (w_state_nxt == c_ST_LOAD);
            r_rf_write_en <= (w_state_nxt == c_ST_WB);
            r_busy        <= (w_state_nxt != c_ST_IDLE) && (w_state_nxt != c_ST_HALT);
            r_halted      <= (w_state_nxt == c_ST_HALT);
        end
    end

    assign imem_req    = r_imem_req;
    assign pc          = r_pc;
    assign ir_write_en = r_ir_write_en;
    assign rf_write_en = r_rf_write_en;
    assign alu_op      = r_alu_op;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign fetch_err   = r_fetch_err;
    assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_seq_ctrl
// Purpose  : Directed self-checking bench for instr_seq_ctrl. Models the
//            instruction memory (programmable wait latency) and the IR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_seq_ctrl;

    localparam int PC_W    = 8;
    localparam int TIMEOUT = 15;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            start      = 1'b0;
    logic [15:0]     instr      = 16'h0000;
    logic            imem_ready = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] pc;
    logic            ir_write_en;
    logic            rf_write_en;
    logic [3:0]      alu_op;
    logic            busy;
    logic            halted;
    logic            fetch_err;
    logic            illegal;

    logic [15:0] mem [256];
    int          lat     = 0;
    int          req_cnt = 0;
    int          tests   = 0;
    int          fails   = 0;

    instr_seq_ctrl #(
        .PC_W    (PC_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instr       (instr),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .pc          (pc),
        .ir_write_en (ir_write_en),
        .rf_write_en (rf_write_en),
        .alu_op      (alu_op),
        .busy        (busy),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // IR: captures memory data at pc on the write-enable edge.
    always @(posedge clk) begin
        if (ir_write_en) instr <= mem[pc];
    end

    // Memory: ready goes high on the (lat+1)-th cycle of a request.
    always @(negedge clk) begin
        if (imem_req) begin
            imem_ready = (req_cnt == lat);
            req_cnt    = req_cnt + 1;
        end else begin
            imem_ready = 1'b0;
            req_cnt    = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"},        32'(pc),          32'h0);
        check({tag, "_imem_req"},  32'(imem_req),    32'h0);
        check({tag, "_ir_we"},     32'(ir_write_en), 32'h0);
        check({tag, "_rf_we"},     32'(rf_write_en), 32'h0);
        check({tag, "_alu_op"},    32'(alu_op),      32'h0);
        check({tag, "_busy"},      32'(busy),        32'h0);
        check({tag, "_halted"},    32'(halted),      32'h0);
        check({tag, "_fetch_err"}, 32'(fetch_err),   32'h0);
        check({tag, "_illegal"},   32'(illegal),     32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Power-on reset
        #2;
        check_reset("por");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_req",  32'(imem_req), 32'h0);

        // NOP stream with zero-wait memory (F=1, 3 cycles each)
        lat   = 0;
        start = 1'b1;
        tick();                                     // FETCH pc0
        start = 1'b0;
        check("nop_fetch_req", 32'(imem_req), 32'h1);
        check("nop_fetch_pc",  32'(pc), 32'h0);
        check("nop_busy",      32'(busy), 32'h1);
        tick();                                     // LOAD
        check("nop_load_irwe", 32'(ir_write_en), 32'h1);
        check("nop_load_req",  32'(imem_req), 32'h0);
        tick();                                     // DECODE
        check("nop_dec_irwe", 32'(ir_write_en), 32'h0);
        check("nop_dec_pc",   32'(pc), 32'h1);
        repeat (13) tick();                         // FETCH pc5
        check("mid_fetch_pc",  32'(pc), 32'h5);
        check("mid_fetch_req", 32'(imem_req), 32'h1);

        // Asynchronous reset mid-fetch, checked before any clock edge
        rst = 1'b1;
        #1;
        check_reset("async");
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_pc",   32'(pc), 32'h0);

        // ALU / illegal / JMP / wrap / HALT program with one wait cycle (F=2)
        mem[0]   = 16'h1234;
        mem[1]   = 16'hA000;
        mem[2]   = 16'h80FF;
        mem[255] = 16'h0000;
        lat      = 1;
        start    = 1'b1;
        tick();                                     // E0 FETCH
        start = 1'b0;
        check("alu_f1_req", 32'(imem_req), 32'h1);
        tick();                                     // E1 FETCH
        check("alu_f2_req",  32'(imem_req), 32'h1);
        check("alu_f2_irwe", 32'(ir_write_en), 32'h0);
        tick();                                     // E2 LOAD (cycle 3)
        check("alu_load_irwe", 32'(ir_write_en), 32'h1);
        check("alu_load_req",  32'(imem_req), 32'h0);
        check("alu_load_pc",   32'(pc), 32'h0);
        tick();                                     // E3 DECODE
        check("alu_dec_irwe", 32'(ir_write_en), 32'h0);
        check("alu_dec_pc",   32'(pc), 32'h1);
        mem[0] = 16'hF000;
        tick();                                     // E4 EXEC
        check("alu_exec_op",   32'(alu_op), 32'h1);
        check("alu_exec_rfwe", 32'(rf_write_en), 32'h0);
        tick();                                     // E5 WB (cycle 6)
        check("alu_wb_rfwe", 32'(rf_write_en), 32'h1);
        check("alu_wb_op",   32'(alu_op), 32'h1);
        tick();                                     // E6 FETCH pc1
        check("alu_next_rfwe", 32'(rf_write_en), 32'h0);
        check("alu_next_req",  32'(imem_req), 32'h1);
        check("alu_next_pc",   32'(pc), 32'h1);
        start = 1'b1;                               // ignored while busy
        tick();                                     // E7 FETCH
        tick();                                     // E8 LOAD
        tick();                                     // E9 DECODE
        start = 1'b0;
        check("ill_dec_pc",   32'(pc), 32'h2);
        check("ill_dec_rfwe", 32'(rf_write_en), 32'h0);
        tick();                                     // E10 FETCH pc2
        check("ill_flag",      32'(illegal), 32'h1);
        check("ill_next_req",  32'(imem_req), 32'h1);
        check("ill_next_pc",   32'(pc), 32'h2);
        check("ill_next_rfwe", 32'(rf_write_en), 32'h0);
        tick();                                     // E11 FETCH
        tick();                                     // E12 LOAD
        tick();                                     // E13 DECODE
        check("jmp_dec_pc", 32'(pc), 32'h3);
        tick();                                     // E14 EXEC
        check("jmp_exec_req",  32'(imem_req), 32'h0);
        check("jmp_exec_op",   32'(alu_op), 32'h1);
        check("jmp_exec_rfwe", 32'(rf_write_en), 32'h0);
        tick();                                     // E15 FETCH pcFF
        check("jmp_target_pc", 32'(pc), 32'hFF);
        check("jmp_next_req",  32'(imem_req), 32'h1);
        check("jmp_ill_held",  32'(illegal), 32'h1);
        tick();                                     // E16 FETCH
        tick();                                     // E17 LOAD
        check("wrap_load_pc",   32'(pc), 32'hFF);
        check("wrap_load_irwe", 32'(ir_write_en), 32'h1);
        tick();                                     // E18 DECODE
        check("wrap_pc", 32'(pc), 32'h0);
        tick();                                     // E19 FETCH pc0
        check("wrap_fetch_req", 32'(imem_req), 32'h1);
        tick();                                     // E20 FETCH
        tick();                                     // E21 LOAD
        tick();                                     // E22 DECODE
        check("halt_dec_pc", 32'(pc), 32'h1);
        tick();                                     // E23 HALT
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_busy",   32'(busy), 32'h0);
        check("halt_req",    32'(imem_req), 32'h0);
        check("halt_ill",    32'(illegal), 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("halt_start_halted", 32'(halted), 32'h1);
        check("halt_start_pc",     32'(pc), 32'h1);
        check("halt_start_req",    32'(imem_req), 32'h0);
        rst = 1'b1;
        #1;
        check_reset("halt_rst");
        #1;
        rst = 1'b0;
        tick();

        // Fetch timeout: memory never answers
        lat   = 255;
        start = 1'b1;
        tick();                                     // E0 FETCH
        start = 1'b0;
        repeat (TIMEOUT - 1) tick();                // E14, last allowed FETCH
        check("to_last_req", 32'(imem_req), 32'h1);
        check("to_last_err", 32'(fetch_err), 32'h0);
        tick();                                     // E15 HALT
        check("to_halted", 32'(halted), 32'h1);
        check("to_err",    32'(fetch_err), 32'h1);
        check("to_busy",   32'(busy), 32'h0);
        check("to_req",    32'(imem_req), 32'h0);
        rst = 1'b1;
        #1;
        check("to_rst_err",    32'(fetch_err), 32'h0);
        check("to_rst_halted", 32'(halted), 32'h0);
        #1;
        rst = 1'b0;
        tick();

        // Ready arrives in the TIMEOUT-th fetch cycle: success
        lat   = TIMEOUT - 1;
        start = 1'b1;
        tick();                                     // E0 FETCH
        start = 1'b0;
        repeat (TIMEOUT - 1) tick();                // E14
        check("edge_last_req", 32'(imem_req), 32'h1);
        tick();                                     // E15 LOAD
        check("edge_load_irwe", 32'(ir_write_en), 32'h1);
        check("edge_load_err",  32'(fetch_err), 32'h0);
        check("edge_load_busy", 32'(busy), 32'h1);
        tick();                                     // E16 DECODE
        check("edge_dec_pc", 32'(pc), 32'h1);
        tick();                                     // E17 HALT (mem[0]=F000)
        check("edge_halted", 32'(halted), 32'h1);
        check("edge_err",    32'(fetch_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
